// File: rtl/pgr_fft_ctrl.sv
// pgr_fft_ctrl -- radix-2 in-place FFT address/control sequencer.
// Issues one butterfly pair per RUN cycle, drains the RAM and butterfly
// pipeline between levels, and delays strobes and addresses to line up
// with the multiplier and the write-back port.
// Optional feature macro: PGR_FFT_CTRL_HOLD_EN (issue stall via hold).
module pgr_fft_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MEM_RD_LAT    = 1,
  parameter int BUTTERFLY_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          hold,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr_a,
  output logic [ADDR_WIDTH-1:0]         rd_addr_b,
  output logic [ADDR_WIDTH-2:0]         tw_addr,
  output logic                          mult_en,
  output logic                          first_lev_s,
  output logic [ADDR_WIDTH-1:0]         fft_i_index,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr_a,
  output logic [ADDR_WIDTH-1:0]         wr_addr_b,
  output logic [$clog2(ADDR_WIDTH)-1:0] level
);

  localparam int LW  = $clog2(ADDR_WIDTH);
  localparam int TOT = MEM_RD_LAT + BUTTERFLY_LAT;
  localparam logic [2:0]    DRAIN_LAST = 3'(TOT - 1);
  localparam logic [LW-1:0] LAST_S     = LW'(ADDR_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-2:0] r_k;
  logic [LW-1:0]         r_s;
  logic [2:0]            r_dcnt;
  logic                  w_hold;
  logic                  w_issue;
  logic                  w_drain_end;

`ifdef PGR_FFT_CTRL_HOLD_EN
  assign w_hold = hold;
`else
  logic w_unused_hold;
  assign w_unused_hold = hold;
  assign w_hold        = 1'b0;
`endif

  assign w_issue     = (r_state == S_RUN) && !w_hold;
  assign w_drain_end = (r_state == S_DRAIN) && (r_dcnt == DRAIN_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: RUN issues a level, DRAIN waits out the pipeline so the
  // next level never reads ahead of the last write of this one
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && (r_k == '1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_state_nxt = (r_s == LAST_S) ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Butterfly index k, level s and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_s    <= '0;
      r_dcnt <= '0;
    end else begin
      // k is N/2 wide, so it wraps to 0 after the last butterfly of a level
      if (w_issue) r_k <= r_k + 1'b1;
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt + 1'b1;
      else                    r_dcnt <= '0;
      if (w_drain_end) r_s <= (r_s == LAST_S) ? '0 : r_s + 1'b1;
    end
  end

  // Address generation: split k at bit s and insert a 0 there
  logic [ADDR_WIDTH-1:0] w_bit, w_mask, w_k_ext, w_addr_a, w_addr_b;
  logic [ADDR_WIDTH-2:0] w_tw;
  logic [LW-1:0]         w_tw_sh;

  assign w_bit    = ADDR_WIDTH'(1) << r_s;
  assign w_mask   = w_bit - ADDR_WIDTH'(1);
  assign w_k_ext  = {1'b0, r_k};
  assign w_addr_a = ((w_k_ext & ~w_mask) << 1) | (w_k_ext & w_mask);
  assign w_addr_b = w_addr_a | w_bit;
  assign w_tw_sh  = LW'(ADDR_WIDTH - 1) - r_s;
  assign w_tw     = (r_k & w_mask[ADDR_WIDTH-2:0]) << w_tw_sh;

  // Addresses are zeroed when no pair is issued so idle outputs stay quiet
  assign rd_en     = w_issue;
  assign rd_addr_a = w_issue ? w_addr_a : '0;
  assign rd_addr_b = w_issue ? w_addr_b : '0;
  assign tw_addr   = w_issue ? w_tw     : '0;

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign level = r_s;

  // Delay lines: pure shift registers, independent of the FSM
  logic                  r_en_dly [1:TOT];
  logic [ADDR_WIDTH-1:0] r_a_dly  [1:TOT];
  logic [ADDR_WIDTH-1:0] r_b_dly  [1:TOT];
  logic                  r_fl_dly [1:MEM_RD_LAT];

  // Shift strobes and addresses one stage per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= TOT; i++) begin
        r_en_dly[i] <= 1'b0;
        r_a_dly[i]  <= '0;
        r_b_dly[i]  <= '0;
      end
      for (int i = 1; i <= MEM_RD_LAT; i++) r_fl_dly[i] <= 1'b0;
    end else begin
      r_en_dly[1] <= rd_en;
      r_a_dly[1]  <= rd_addr_a;
      r_b_dly[1]  <= rd_addr_b;
      r_fl_dly[1] <= w_issue && (r_s == '0);
      for (int i = 2; i <= TOT; i++) begin
        r_en_dly[i] <= r_en_dly[i-1];
        r_a_dly[i]  <= r_a_dly[i-1];
        r_b_dly[i]  <= r_b_dly[i-1];
      end
      for (int i = 2; i <= MEM_RD_LAT; i++) r_fl_dly[i] <= r_fl_dly[i-1];
    end
  end

  assign mult_en     = r_en_dly[MEM_RD_LAT];
  assign fft_i_index = r_a_dly[MEM_RD_LAT];
  assign first_lev_s = r_fl_dly[MEM_RD_LAT];
  assign wr_en       = r_en_dly[TOT];
  assign wr_addr_a   = r_a_dly[TOT];
  assign wr_addr_b   = r_b_dly[TOT];

endmodule

// File: tb/tb_pgr_fft_ctrl.sv
// tb_pgr_fft_ctrl -- cycle trace bench for pgr_fft_ctrl (N=8, latencies 1/1).
// Expected traces come from a schedule model: FFT levels, butterflies, holds
// and drain gaps laid out on a cycle timeline with plain arithmetic.
module tb_pgr_fft_ctrl;
  localparam int AW   = 3;
  localparam int N    = 8;
  localparam int MRL  = 1;
  localparam int BL   = 1;
  localparam int TOT  = MRL + BL;
  localparam int MAXC = 128;
`ifdef PGR_FFT_CTRL_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          busy, done, rd_en, mult_en, first_lev_s, wr_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, fft_i_index, wr_addr_a, wr_addr_b;
  logic [AW-2:0] tw_addr;
  logic [1:0]    level;

  pgr_fft_ctrl #(.ADDR_WIDTH(AW), .MEM_RD_LAT(MRL), .BUTTERFLY_LAT(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .mult_en(mult_en), .first_lev_s(first_lev_s), .fft_i_index(fft_i_index),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, rd, me, fl, wr;
    logic [2:0] a, b;
    logic [1:0] tw, lv;
    logic [2:0] fi, wa, wb;
  } obs_t;

  obs_t e [MAXC];
  bit   st[MAXC];
  bit   hd[MAXC];
  int   vecs = 0;
  int   errs = 0;

  function automatic void clear_stim();
    for (int c = 0; c < MAXC; c++) begin st[c] = 1'b0; hd[c] = 1'b0; end
  endfunction

  function automatic void clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) e[c] = '0;
  endfunction

  // Lay one FFT onto the timeline starting with start sampled at c0
  function automatic int schedule(input int c0);
    int t = c0 + 1;
    for (int s = 0; s < AW; s++) begin
      int p = 1 << s;
      for (int k = 0; k < N/2; k++) begin
        int lo, a;
        while (HOLD_EN && hd[t] && t < MAXC - 8) begin e[t].busy = 1'b1; t++; end
        lo = k % p;
        a  = (k / p) * 2 * p + lo;
        e[t].busy = 1'b1; e[t].rd = 1'b1;
        e[t].a  = 3'(a);  e[t].b = 3'(a + p);
        e[t].tw = 2'(lo * ((N/2) / p));
        e[t].lv = 2'(s);
        e[t+MRL].me = 1'b1; e[t+MRL].fl = (s == 0); e[t+MRL].fi = 3'(a);
        e[t+TOT].wr = 1'b1; e[t+TOT].wa = 3'(a); e[t+TOT].wb = 3'(a + p);
        t++;
      end
      for (int i = 0; i < TOT; i++) begin e[t].busy = 1'b1; t++; end
    end
    e[t].busy = 1'b1; e[t].done = 1'b1;
    return t;
  endfunction

  // Build expected trace; rc >= 0 means reset held low during cycles rc, rc+1
  function automatic void build_model(input int len, input int rc);
    int nf = 0;
    clear_from(0);
    for (int c = 0; c < len; c++) begin
      if (c == rc) begin clear_from(rc); nf = rc + 2; end
      if (st[c] && c >= nf) nf = schedule(c) + 1;
    end
  endfunction

  task automatic step(input int c, input int rc);
    @(posedge clk); #1;
    rst_n = !(rc >= 0 && (c == rc || c == rc + 1));
    start = st[c];
    hold  = hd[c];
    @(negedge clk);
  endtask

  // DUT outputs; address fields only matter where their strobe is expected
  function automatic obs_t sample(input int c);
    obs_t o;
    o.busy = busy; o.done = done; o.rd = rd_en; o.me = mult_en;
    o.fl = first_lev_s; o.wr = wr_en;
    o.a  = e[c].rd ? rd_addr_a : '0;
    o.b  = e[c].rd ? rd_addr_b : '0;
    o.tw = e[c].rd ? tw_addr   : '0;
    o.lv = e[c].rd ? level     : '0;
    o.fi = e[c].me ? fft_i_index : '0;
    o.wa = e[c].wr ? wr_addr_a : '0;
    o.wb = e[c].wr ? wr_addr_b : '0;
    return o;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (busy !== 1'b0)   begin $display("FAIL reset_busy got %b exp 0", busy); errs++; end
    vecs++;
    if (done !== 1'b0)   begin $display("FAIL reset_done got %b exp 0", done); errs++; end
    vecs++;
    if (rd_en !== 1'b0)  begin $display("FAIL reset_rd_en got %b exp 0", rd_en); errs++; end
    vecs++;
    if (rd_addr_b !== '0) begin $display("FAIL reset_rd_addr_b got %h exp 0", rd_addr_b); errs++; end
    vecs++;
    if ({mult_en, first_lev_s, wr_en} !== 3'b000) begin
      $display("FAIL reset_dly got %b exp 000", {mult_en, first_lev_s, wr_en}); errs++;
    end
    vecs++;
    if (level !== '0)    begin $display("FAIL reset_level got %0d exp 0", level); errs++; end
    vecs++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_levels();
    obs_t o;
    clear_stim(); st[0] = 1'b1;
    build_model(24, -1);
    for (int c = 0; c < 24; c++) begin
      step(c, -1); o = sample(c);
      if (o !== e[c]) begin $display("FAIL levels cyc %0d got %h exp %h", c, o, e[c]); errs++; end
      vecs++;
    end
  endtask

  task automatic test_start_ignored();
    obs_t o;
    clear_stim(); st[0] = 1'b1; st[5] = 1'b1; st[19] = 1'b1;
    build_model(24, -1);
    for (int c = 0; c < 24; c++) begin
      step(c, -1); o = sample(c);
      if (o !== e[c]) begin $display("FAIL start_ignored cyc %0d got %h exp %h", c, o, e[c]); errs++; end
      vecs++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    clear_stim(); st[0] = 1'b1; st[12] = 1'b1;
    build_model(36, 8);
    for (int c = 0; c < 36; c++) begin
      step(c, 8); o = sample(c);
      if (o !== e[c]) begin $display("FAIL reset_mid cyc %0d got %h exp %h", c, o, e[c]); errs++; end
      vecs++;
    end
  endtask

  task automatic test_hold();
    obs_t o;
    clear_stim(); st[0] = 1'b1; hd[2] = 1'b1; hd[3] = 1'b1;
    build_model(26, -1);
    for (int c = 0; c < 26; c++) begin
      step(c, -1); o = sample(c);
      if (o !== e[c]) begin $display("FAIL hold cyc %0d got %h exp %h", c, o, e[c]); errs++; end
      vecs++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    clear_stim(); st[0] = 1'b1; st[20] = 1'b1;
    build_model(44, -1);
    for (int c = 0; c < 44; c++) begin
      step(c, -1); o = sample(c);
      if (o !== e[c]) begin $display("FAIL back_to_back cyc %0d got %h exp %h", c, o, e[c]); errs++; end
      vecs++;
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int it = 0; it < 4; it++) begin
      clear_stim();
      for (int c = 0; c < 20; c++) st[c] = ($urandom_range(0, 5) == 0);
      st[$urandom_range(0, 19)] = 1'b1;
      for (int c = 0; c < 60; c++) hd[c] = ($urandom_range(0, 3) == 0);
      build_model(100, -1);
      for (int c = 0; c < 100; c++) begin
        step(c, -1); o = sample(c);
        if (o !== e[c]) begin
          $display("FAIL random it %0d cyc %0d got %h exp %h", it, c, o, e[c]); errs++;
        end
        vecs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_start_ignored();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    test_random();
    start = 1'b0; hold = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
